// File: rtl/minc_stack.sv
// minc_stack -- parametrised operand stack for the minc core.
//
// Executes one stack op per rising clock edge. The stack is kept as a shift
// register whose entry 0 is the top, so top_out/second_out come straight
// from flops. Positions at or above the stack pointer always hold zero,
// which makes vacated positions read as 0 without extra masking.
//
// Ports:
//   CLK        clock, all state updates on the rising edge
//   RESET      asynchronous active-high reset
//   op         0 NOP, 1 PUSH, 2 POP, 3 DUP, 4 SWAP, 5 OVER, 6 REPL, 7 CLRERR
//   din        operand for PUSH / REPL
//   top_out    top entry (0 when empty)
//   second_out entry below top (0 when fewer than two entries)
//   sp_out     number of valid entries, 0..DEPTH
//   empty      sp_out == 0
//   full       sp_out == DEPTH
//   overflow   sticky: push-class op attempted while full
//   underflow  sticky: op needed more entries than present
module minc_stack #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    parameter bit WRAP  = 1'b0
) (
    input  logic                         CLK,
    input  logic                         RESET,
    input  logic [2:0]                   op,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             top_out,
    output logic [WIDTH-1:0]             second_out,
    output logic [$clog2(DEPTH+1)-1:0]   sp_out,
    output logic                         empty,
    output logic                         full,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int SP_W = $clog2(DEPTH+1);
    localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

    typedef enum logic [2:0] {
        OP_NOP    = 3'd0,
        OP_PUSH   = 3'd1,
        OP_POP    = 3'd2,
        OP_DUP    = 3'd3,
        OP_SWAP   = 3'd4,
        OP_OVER   = 3'd5,
        OP_REPL   = 3'd6,
        OP_CLRERR = 3'd7
    } op_e;

    op_e              op_s;
    logic [WIDTH-1:0] stk_q [DEPTH];
    logic [WIDTH-1:0] stk_d [DEPTH];
    logic [SP_W-1:0]  sp_q, sp_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty_q, full_q;

    logic             have1, have2, is_full;
    logic             push_en, pop_en;
    logic [WIDTH-1:0] push_val;

    always_comb op_s = op_e'(op);

    always_comb begin
        have1   = (sp_q != '0);
        have2   = (sp_q > SP_W'(1));
        is_full = (sp_q == SP_MAX);
    end

    always_comb begin
        stk_d    = stk_q;
        sp_d     = sp_q;
        ovf_d    = ovf_q;
        unf_d    = unf_q;
        push_en  = 1'b0;
        pop_en   = 1'b0;
        push_val = din;

        // Entry-count checks come first so an op that is short of entries
        // reports underflow even when the stack is also full.
        case (op_s)
            OP_NOP: ;
            OP_PUSH: begin
                push_en  = 1'b1;
                push_val = din;
            end
            OP_DUP: begin
                if (have1) begin
                    push_en  = 1'b1;
                    push_val = stk_q[0];
                end else begin
                    unf_d = 1'b1;
                end
            end
            OP_OVER: begin
                if (have2) begin
                    push_en  = 1'b1;
                    push_val = stk_q[1];
                end else begin
                    unf_d = 1'b1;
                end
            end
            OP_POP: begin
                if (have1) pop_en = 1'b1;
                else       unf_d  = 1'b1;
            end
            OP_SWAP: begin
                if (have2) begin
                    stk_d[0] = stk_q[1];
                    stk_d[1] = stk_q[0];
                end else begin
                    unf_d = 1'b1;
                end
            end
            OP_REPL: begin
                if (have1) stk_d[0] = din;
                else       unf_d    = 1'b1;
            end
            OP_CLRERR: begin
                ovf_d = 1'b0;
                unf_d = 1'b0;
            end
        endcase

        if (push_en) begin
            if (is_full) ovf_d = 1'b1;
            // In wrap mode the shift naturally discards the bottom entry.
            if (!is_full || WRAP) begin
                for (int unsigned i = DEPTH - 1; i >= 1; i--) begin
                    stk_d[i] = stk_q[i-1];
                end
                stk_d[0] = push_val;
                if (!is_full) sp_d = sp_q + SP_W'(1);
            end
        end

        if (pop_en) begin
            for (int unsigned i = 0; i < DEPTH - 1; i++) begin
                stk_d[i] = stk_q[i+1];
            end
            stk_d[DEPTH-1] = '0;
            sp_d = sp_q - SP_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stk_q[i] <= '0;
            end
            sp_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            stk_q   <= stk_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            empty_q <= (sp_d == '0);
            full_q  <= (sp_d == SP_MAX);
        end
    end

    assign top_out    = stk_q[0];
    assign second_out = stk_q[1];
    assign sp_out     = sp_q;
    assign empty      = empty_q;
    assign full       = full_q;
    assign overflow   = ovf_q;
    assign underflow  = unf_q;

endmodule

// File: tb/tb_minc_stack.sv
// Directed bench for minc_stack: one instance with WRAP=0 and one with
// WRAP=1, both WIDTH=8 / DEPTH=4, driven by the same op stream.
module tb_minc_stack;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, DUP = 3'd3,
                           SWAP = 3'd4, OVER = 3'd5, REPL = 3'd6, CLRERR = 3'd7;

    logic       clk;
    logic       rst;
    logic [2:0] op;
    logic [7:0] din;

    logic [7:0] top0, sec0, top1, sec1;
    logic [2:0] sp0, sp1;
    logic       emp0, ful0, ovf0, unf0;
    logic       emp1, ful1, ovf1, unf1;

    int n_vec;
    int n_err;

    minc_stack #(.WIDTH(8), .DEPTH(4), .WRAP(1'b0)) dut0 (
        .CLK(clk), .RESET(rst), .op(op), .din(din),
        .top_out(top0), .second_out(sec0), .sp_out(sp0),
        .empty(emp0), .full(ful0), .overflow(ovf0), .underflow(unf0)
    );

    minc_stack #(.WIDTH(8), .DEPTH(4), .WRAP(1'b1)) dut1 (
        .CLK(clk), .RESET(rst), .op(op), .din(din),
        .top_out(top1), .second_out(sec1), .sp_out(sp1),
        .empty(emp1), .full(ful1), .overflow(ovf1), .underflow(unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Present an op, let one rising edge take it, sample 1 ns later.
    task automatic step(input logic [2:0] o, input logic [7:0] d);
        op  = o;
        din = d;
        @(posedge clk);
        #1;
        op  = NOP;
        din = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        op    = NOP;
        din   = '0;
        rst   = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        check("rst_sp",    32'(sp0), 0);
        check("rst_top",   32'(top0), 0);
        check("rst_empty", 32'(emp0), 1);
        check("rst_flags", {30'd0, ovf0, unf0}, 0);

        // Reset asserted mid-sequence after three pushes.
        step(PUSH, 8'd11);
        step(PUSH, 8'd22);
        step(PUSH, 8'd33);
        check("pre_rst_sp", 32'(sp0), 3);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_rst_sp", 32'(sp0), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_sp",    32'(sp0), 0);
        check("mid_rst_top",   32'(top0), 0);
        check("mid_rst_empty", 32'(emp0), 1);
        check("mid_rst_flags", {30'd0, ovf0, unf0}, 0);

        // PUSH / SWAP / OVER.
        step(PUSH, 8'd11);
        step(PUSH, 8'd22);
        step(PUSH, 8'd33);
        check("push3_top", 32'(top0), 33);
        check("push3_sec", 32'(sec0), 22);
        check("push3_sp",  32'(sp0), 3);
        step(SWAP, 8'd0);
        check("swap_top", 32'(top0), 22);
        check("swap_sec", 32'(sec0), 33);
        check("swap_sp",  32'(sp0), 3);
        step(OVER, 8'd0);
        check("over_top",  32'(top0), 33);
        check("over_sec",  32'(sec0), 22);
        check("over_sp",   32'(sp0), 4);
        check("over_full", 32'(ful0), 1);
        check("over_ovf",  32'(ovf0), 0);
        step(PUSH, 8'd99);
        check("rej_push_top", 32'(top0), 33);
        check("rej_push_sp",  32'(sp0), 4);
        check("rej_push_ovf", 32'(ovf0), 1);

        // Overflow behaviour, both modes.
        do_reset();
        for (int i = 1; i <= 5; i++) step(PUSH, 8'(i));
        check("w0_sp",  32'(sp0), 4);
        check("w0_top", 32'(top0), 4);
        check("w0_ovf", 32'(ovf0), 1);
        check("w1_sp",  32'(sp1), 4);
        check("w1_top", 32'(top1), 5);
        check("w1_sec", 32'(sec1), 4);
        check("w1_ovf", 32'(ovf1), 1);
        check("w1_full", 32'(ful1), 1);

        step(POP, 8'd0);
        check("w0_pop1_top", 32'(top0), 3);
        check("w1_pop1_top", 32'(top1), 4);
        check("w0_pop1_full", 32'(ful0), 0);
        step(POP, 8'd0);
        step(POP, 8'd0);
        check("w0_pop3_top", 32'(top0), 1);
        check("w0_pop3_sec", 32'(sec0), 0);
        check("w1_pop3_top", 32'(top1), 2);
        check("w1_pop3_sec", 32'(sec1), 0);
        check("w1_pop3_sp",  32'(sp1), 1);
        step(POP, 8'd0);
        check("w0_pop4_sp",    32'(sp0), 0);
        check("w0_pop4_top",   32'(top0), 0);
        check("w0_pop4_empty", 32'(emp0), 1);
        check("w1_pop4_top",   32'(top1), 0);
        step(POP, 8'd0);
        check("pop_empty_unf", 32'(unf0), 1);
        check("pop_empty_ovf", 32'(ovf0), 1);
        check("pop_empty_sp",  32'(sp0), 0);
        step(CLRERR, 8'd0);
        check("clr_flags0", {30'd0, ovf0, unf0}, 0);
        check("clr_flags1", {30'd0, ovf1, unf1}, 0);

        // Single-entry underflow cases and REPL.
        step(PUSH, 8'd7);
        step(SWAP, 8'd0);
        check("swap1_top", 32'(top0), 7);
        check("swap1_sp",  32'(sp0), 1);
        check("swap1_unf", 32'(unf0), 1);
        step(OVER, 8'd0);
        check("over1_sp",  32'(sp0), 1);
        check("over1_ovf", 32'(ovf0), 0);
        step(REPL, 8'd9);
        check("repl_top", 32'(top0), 9);
        check("repl_sp",  32'(sp0), 1);
        step(CLRERR, 8'd0);
        check("clr2_flags", {30'd0, ovf0, unf0}, 0);
        check("clr2_top",   32'(top0), 9);

        step(POP, 8'd0);
        step(DUP, 8'd0);
        check("dup0_unf", 32'(unf0), 1);
        check("dup0_sp",  32'(sp0), 0);
        step(REPL, 8'd3);
        check("repl0_top", 32'(top0), 0);
        check("repl0_sp",  32'(sp0), 0);
        step(PUSH, 8'd5);
        step(DUP, 8'd0);
        check("dup_top", 32'(top0), 5);
        check("dup_sec", 32'(sec0), 5);
        check("dup_sp",  32'(sp0), 2);
        check("dup_unf_sticky", 32'(unf0), 1);
        step(NOP, 8'd0);
        check("nop_sp",  32'(sp0), 2);
        check("nop_top", 32'(top0), 5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
